// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// CPU instruction-fetch port and the data-memory port. One transaction is in
// flight at a time. Data requests win, but a fetch is forced through after
// STARVE_MAX consecutive data grants made while a fetch was waiting.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);

    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [SC_W-1:0]  starve_cnt;
    logic             gnt_data;   // current transaction belongs to the data port
    logic             gnt_store;  // current transaction is a store
    logic             pick_data;

    // Data wins unless a fetch is waiting and the data port has used up its run.
    assign pick_data = dm_req && (!if_req || (starve_cnt < SC_W'(STARVE_MAX)));

    // Arbitration FSM; every output is a register driven from this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            gnt_data   <= 1'b0;
            gnt_store  <= 1'b0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_rdata   <= '0;
            dm_valid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below reads the pre-edge values; the pulse defaults here
            // are overridden later in the same block only where a pulse is due.
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        state  <= S_ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (pick_data) begin
                            gnt_data  <= 1'b1;
                            gnt_store <= dm_we;
                            mem_we    <= dm_we;
                            mem_wstrb <= dm_we ? dm_wstrb : STRB_W'(0);
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            // A pending fetch implies starve_cnt < STARVE_MAX here,
                            // so the increment saturates by construction.
                            if (if_req) starve_cnt <= starve_cnt + SC_W'(1);
                            else        starve_cnt <= '0;
                        end else begin
                            gnt_data   <= 1'b0;
                            gnt_store  <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_wstrb  <= '0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= '0;
                    wait_cnt  <= CNT_W'(MEM_LAT - 1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_RESP;
                        if (gnt_data) begin
                            dm_valid <= 1'b1;
                            if (!gnt_store) dm_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: four instances with MEM_LAT=1..4, each on
// its own behavioural memory. Directed steps cover the documented scenarios,
// then a randomized phase on the MEM_LAT=1 instance is checked against a
// transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        if_req_a    [1:4];
    logic [31:0] if_addr_a   [1:4];
    logic [31:0] if_rdata_a  [1:4];
    logic        if_valid_a  [1:4];
    logic        dm_req_a    [1:4];
    logic        dm_we_a     [1:4];
    logic [3:0]  dm_wstrb_a  [1:4];
    logic [31:0] dm_addr_a   [1:4];
    logic [31:0] dm_wdata_a  [1:4];
    logic [31:0] dm_rdata_a  [1:4];
    logic        dm_valid_a  [1:4];
    logic        mem_en_a    [1:4];
    logic        mem_we_a    [1:4];
    logic [3:0]  mem_wstrb_a [1:4];
    logic [31:0] mem_addr_a  [1:4];
    logic [31:0] mem_wdata_a [1:4];
    logic [31:0] mem_rdata_a [1:4];
    logic        busy_a      [1:4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(g), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req_a[g]), .if_addr(if_addr_a[g]),
            .if_rdata(if_rdata_a[g]), .if_valid(if_valid_a[g]),
            .dm_req(dm_req_a[g]), .dm_we(dm_we_a[g]), .dm_wstrb(dm_wstrb_a[g]),
            .dm_addr(dm_addr_a[g]), .dm_wdata(dm_wdata_a[g]),
            .dm_rdata(dm_rdata_a[g]), .dm_valid(dm_valid_a[g]),
            .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_wstrb(mem_wstrb_a[g]),
            .mem_addr(mem_addr_a[g]), .mem_wdata(mem_wdata_a[g]),
            .mem_rdata(mem_rdata_a[g]), .busy(busy_a[g])
        );
    end

    // Initial memory image shared by the memory models and the reference.
    function automatic logic [31:0] init_word(input logic [31:0] addr);
        if (addr == 32'h10)  return 32'h0050_0093;
        if (addr == 32'h200) return 32'h0000_0008;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Behavioural memories: read data appears MEM_LAT cycles after the issue
    // cycle and is random noise at every other time.
    logic        mem_loaded = 1'b0;
    logic [31:0] mem_img [1:4][0:255];
    logic [31:0] rd_pipe [1:4][1:4];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 1; k <= 4; k++)
                for (int i = 0; i < 256; i++) mem_img[k][i] <= init_word(32'(i) << 2);
            mem_loaded <= 1'b1;
        end
        for (int k = 1; k <= 4; k++) begin
            for (int s = 4; s >= 2; s--) rd_pipe[k][s] <= rd_pipe[k][s-1];
            if (mem_en_a[k]) begin
                rd_pipe[k][1] <= mem_img[k][mem_addr_a[k][9:2]];
                if (mem_we_a[k])
                    mem_img[k][mem_addr_a[k][9:2]] <=
                        merge(mem_img[k][mem_addr_a[k][9:2]], mem_wdata_a[k], mem_wstrb_a[k]);
            end else begin
                rd_pipe[k][1] <= $urandom();
            end
        end
    end

    for (genvar g = 1; g <= 4; g++) begin : g_rd
        assign mem_rdata_a[g] = rd_pipe[g][g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int k = 1; k <= 4; k++) begin
            if_req_a[k] = 1'b0;  if_addr_a[k]  = '0;
            dm_req_a[k] = 1'b0;  dm_we_a[k]    = 1'b0;  dm_wstrb_a[k] = '0;
            dm_addr_a[k] = '0;   dm_wdata_a[k] = '0;
        end
    endtask

    logic [31:0] ref_mem [0:255];  // expected contents of instance 1's memory

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          scnt, ndata, nfetch, next_idle, ifv_at, dmv_at;
        logic        last_data, exp_en, pick_d, dmv_store;
        logic [31:0] e_addr, e_wdata, ifv_data, dmv_data, dm_hold, stw;
        logic [3:0]  e_wstrb;
        logic        e_we;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(32'(i) << 2);
        idle_all();
        rst_n = 1'b0;
        repeat (3) step();

        // Reset state of every instance.
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("reset.busy[%0d]", k),     busy_a[k],     0);
            check($sformatf("reset.mem_en[%0d]", k),   mem_en_a[k],   0);
            check($sformatf("reset.if_valid[%0d]", k), if_valid_a[k], 0);
            check($sformatf("reset.dm_valid[%0d]", k), dm_valid_a[k], 0);
            check($sformatf("reset.if_rdata[%0d]", k), if_rdata_a[k], 0);
            check($sformatf("reset.dm_rdata[%0d]", k), dm_rdata_a[k], 0);
            check($sformatf("reset.mem_addr[%0d]", k), mem_addr_a[k], 0);
        end
        rst_n = 1'b1;
        step();

        // 1: lone fetch.
        if_req_a[1] = 1'b1; if_addr_a[1] = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            step();
            check("t1.mem_en", mem_en_a[1], 32'(c == 1));
            if (c == 1) begin
                check("t1.mem_addr", mem_addr_a[1], 32'h10);
                check("t1.mem_we", mem_we_a[1], 0);
            end
            check("t1.if_valid", if_valid_a[1], 32'(c == 3));
            check("t1.dm_valid", dm_valid_a[1], 0);
            if (c == 3) begin
                check("t1.if_rdata", if_rdata_a[1], 32'h0050_0093);
                if_req_a[1] = 1'b0;
            end
        end

        // 2: simultaneous fetch and load; data goes first.
        if_req_a[1] = 1'b1; if_addr_a[1] = 32'h20;
        dm_req_a[1] = 1'b1; dm_we_a[1] = 1'b0; dm_wstrb_a[1] = 4'hF;
        dm_addr_a[1] = 32'h200; dm_wdata_a[1] = 32'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("t2.mem_en", mem_en_a[1], 32'(c == 1 || c == 5));
            if (c == 1) begin
                check("t2.load_addr", mem_addr_a[1], 32'h200);
                check("t2.load_wstrb", mem_wstrb_a[1], 0);
            end
            if (c == 5) begin
                check("t2.fetch_addr", mem_addr_a[1], 32'h20);
                check("t2.fetch_we", mem_we_a[1], 0);
            end
            check("t2.dm_valid", dm_valid_a[1], 32'(c == 3));
            check("t2.if_valid", if_valid_a[1], 32'(c == 7));
            check("t2.busy", busy_a[1], 32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
            if (c == 3) begin
                check("t2.dm_rdata", dm_rdata_a[1], 32'h8);
                dm_req_a[1] = 1'b0;
            end
            if (c == 7) begin
                check("t2.if_rdata", if_rdata_a[1], init_word(32'h20));
                if_req_a[1] = 1'b0;
            end
        end

        // 3: partial store, then read it back.
        dm_req_a[1] = 1'b1; dm_we_a[1] = 1'b1; dm_wstrb_a[1] = 4'b0011;
        dm_addr_a[1] = 32'h100; dm_wdata_a[1] = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("t3.mem_en", mem_en_a[1], 32'(c == 1));
            if (c == 1) begin
                check("t3.mem_we", mem_we_a[1], 1);
                check("t3.mem_wstrb", mem_wstrb_a[1], 32'b0011);
                check("t3.mem_addr", mem_addr_a[1], 32'h100);
                check("t3.mem_wdata", mem_wdata_a[1], 32'hDEAD_BEEF);
            end
            check("t3.dm_valid", dm_valid_a[1], 32'(c == 3));
            check("t3.dm_rdata_held", dm_rdata_a[1], 32'h8);
            check("t3.if_valid", if_valid_a[1], 0);
            if (c == 3) dm_req_a[1] = 1'b0;
        end
        stw = merge(init_word(32'h100), 32'hDEAD_BEEF, 4'b0011);
        ref_mem[32'h100 >> 2] = stw;
        dm_req_a[1] = 1'b1; dm_we_a[1] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("t3.rb_valid", dm_valid_a[1], 32'(c == 3));
            if (c == 3) begin
                check("t3.rb_rdata", dm_rdata_a[1], stw);
                dm_req_a[1] = 1'b0;
            end
        end

        // 4: starvation guard with both ports requesting continuously.
        if_req_a[1] = 1'b1; if_addr_a[1] = 32'h40;
        dm_req_a[1] = 1'b1; dm_we_a[1] = 1'b0; dm_addr_a[1] = 32'h80;
        scnt = 0; ndata = 0; nfetch = 0; last_data = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            check("t4.mem_en", mem_en_a[1], 32'(c % 4 == 1));
            if (c % 4 == 1) begin
                last_data = (scnt < 4);
                check("t4.grant_is_data", 32'(mem_addr_a[1] == 32'h80), 32'(last_data));
                if (mem_addr_a[1] == 32'h80) ndata++; else nfetch++;
                if (last_data) scnt++; else scnt = 0;
            end
            check("t4.dm_valid", dm_valid_a[1], 32'(c % 4 == 3 && last_data));
            check("t4.if_valid", if_valid_a[1], 32'(c % 4 == 3 && !last_data));
            if (c == 39) begin
                if_req_a[1] = 1'b0;
                dm_req_a[1] = 1'b0;
            end
        end
        check("t4.data_grants", ndata, 8);
        check("t4.fetch_grants", nfetch, 2);

        // 5: reset during WAIT on the MEM_LAT=3 instance.
        if_req_a[3] = 1'b1; if_addr_a[3] = 32'h30;
        repeat (3) step();
        check("t5.busy_before", busy_a[3], 1);
        check("t5.addr_before", mem_addr_a[3], 32'h30);
        rst_n = 1'b0;
        #1;
        check("t5.busy", busy_a[3], 0);
        check("t5.mem_en", mem_en_a[3], 0);
        check("t5.mem_addr", mem_addr_a[3], 0);
        check("t5.if_valid", if_valid_a[3], 0);
        check("t5.if_rdata", if_rdata_a[3], 0);
        check("t5.dm_valid", dm_valid_a[3], 0);
        if_req_a[3] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("t5.no_stale_valid", if_valid_a[3], 0);
        end
        if_req_a[3] = 1'b1; if_addr_a[3] = 32'h34;
        for (int c = 1; c <= 6; c++) begin
            step();
            check("t5.new_if_valid", if_valid_a[3], 32'(c == 5));
            if (c == 5) begin
                check("t5.new_if_rdata", if_rdata_a[3], init_word(32'h34));
                if_req_a[3] = 1'b0;
            end
        end

        // 6: latency sweep over all instances.
        for (int k = 1; k <= 4; k++) begin
            if_req_a[k] = 1'b1; if_addr_a[k] = 32'h50 + 32'(4 * k);
            for (int c = 1; c <= k + 4; c++) begin
                step();
                check($sformatf("t6.mem_en[%0d]", k), mem_en_a[k], 32'(c == 1));
                check($sformatf("t6.busy[%0d]", k), busy_a[k], 32'(c <= k + 2));
                check($sformatf("t6.if_valid[%0d]", k), if_valid_a[k], 32'(c == k + 2));
                if (c == k + 2) begin
                    check($sformatf("t6.if_rdata[%0d]", k), if_rdata_a[k],
                          init_word(32'h50 + 32'(4 * k)));
                    if_req_a[k] = 1'b0;
                end
            end
        end

        // Randomized traffic on instance 1 against a transaction-level model.
        scnt = 0; next_idle = 0; ifv_at = -1; dmv_at = -1;
        ifv_data = '0; dmv_data = '0; dmv_store = 1'b0; dm_hold = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            step();
            exp_en = 1'b0; e_addr = '0; e_we = 1'b0; e_wstrb = '0; e_wdata = '0;
            if (cyc - 1 >= next_idle) begin
                if (!if_req_a[1]) scnt = 0;
                if (if_req_a[1] || dm_req_a[1]) begin
                    exp_en    = 1'b1;
                    next_idle = cyc + 3;
                    pick_d    = dm_req_a[1] && (!if_req_a[1] || scnt < 4);
                    if (pick_d) begin
                        if (if_req_a[1]) scnt++;
                        e_addr  = dm_addr_a[1];
                        e_we    = dm_we_a[1];
                        e_wstrb = dm_we_a[1] ? dm_wstrb_a[1] : 4'h0;
                        e_wdata = dm_wdata_a[1];
                        dmv_at  = cyc + 2;
                        dmv_store = dm_we_a[1];
                        if (dm_we_a[1])
                            ref_mem[e_addr[9:2]] = merge(ref_mem[e_addr[9:2]], e_wdata, e_wstrb);
                        else
                            dmv_data = ref_mem[e_addr[9:2]];
                    end else begin
                        scnt     = 0;
                        e_addr   = if_addr_a[1];
                        ifv_at   = cyc + 2;
                        ifv_data = ref_mem[e_addr[9:2]];
                    end
                end
            end
            check("rnd.mem_en", mem_en_a[1], 32'(exp_en));
            if (exp_en) begin
                check("rnd.mem_addr", mem_addr_a[1], e_addr);
                check("rnd.mem_we", mem_we_a[1], 32'(e_we));
                check("rnd.mem_wstrb", mem_wstrb_a[1], 32'(e_wstrb));
                if (e_we) check("rnd.mem_wdata", mem_wdata_a[1], e_wdata);
            end
            check("rnd.if_valid", if_valid_a[1], 32'(cyc == ifv_at));
            check("rnd.dm_valid", dm_valid_a[1], 32'(cyc == dmv_at));
            if (cyc == ifv_at) begin
                check("rnd.if_rdata", if_rdata_a[1], ifv_data);
                if_req_a[1] = 1'b0;
            end
            if (cyc == dmv_at) begin
                if (dmv_store) begin
                    check("rnd.store_rdata_held", dm_rdata_a[1], dm_hold);
                end else begin
                    check("rnd.dm_rdata", dm_rdata_a[1], dmv_data);
                    dm_hold = dmv_data;
                end
                dm_req_a[1] = 1'b0;
            end
            if (cyc < 380 && !if_req_a[1] && $urandom_range(0, 2) != 0) begin
                if_req_a[1]  = 1'b1;
                if_addr_a[1] = {22'b0, 8'($urandom()), 2'b00};
            end
            if (cyc < 380 && !dm_req_a[1] && $urandom_range(0, 2) != 0) begin
                dm_req_a[1]   = 1'b1;
                dm_we_a[1]    = 1'($urandom_range(0, 1));
                dm_wstrb_a[1] = 4'($urandom());
                dm_addr_a[1]  = {22'b0, 8'($urandom()), 2'b00};
                dm_wdata_a[1] = $urandom();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
